// File: rtl/pls_pacer_if.sv
// Handshake bundle between an event source and the pls_pacer.
// The master raises events; the slave (the pacer) returns paced pulses and status.
interface pls_pacer_if #(
  parameter int pCNT_W = 4
);
  logic              req;
  logic              clr;
  logic              pls;
  logic [pCNT_W-1:0] pending;
  logic              busy;
  logic              ovf;

  modport master (
    output req,
    output clr,
    input  pls,
    input  pending,
    input  busy,
    input  ovf
  );

  modport slave (
    input  req,
    input  clr,
    output pls,
    output pending,
    output busy,
    output ovf
  );
endinterface

// File: rtl/pls_pacer.sv
// Sending-domain event pacer: queues requests in a saturating counter and emits
// registered single-cycle pulses spaced at least pGAP clocks apart.
module pls_pacer #(
  parameter int pGAP   = 6,
  parameter int pCNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  pls_pacer_if.slave bus
);

  localparam int                GAP_W    = $clog2(pGAP);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(pGAP - 1);
  localparam logic [pCNT_W-1:0] PEND_MAX = '1;

  typedef enum logic {
    ST_IDLE,
    ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [pCNT_W-1:0]  pending_q, pending_d;
  logic               pls_q, pls_d;
  logic               ovf_q, ovf_d;
  logic               fire;
  logic               gap_zero;
  logic               drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A GAP that expires with nothing to send falls back to IDLE; a backlog re-fires in place.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fire) state_d = ST_GAP;
      ST_GAP:  if (gap_zero && !fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gap_zero = (gap_cnt_q == '0);
    if (bus.clr) begin
      fire = 1'b0;
    end else if (state_q == ST_IDLE) begin
      fire = bus.req;
    end else begin
      fire = gap_zero && ((pending_q != '0) || bus.req);
    end

    drop = bus.req && !bus.clr && !fire && (pending_q == PEND_MAX);

    pending_d = pending_q;
    if (bus.clr) begin
      pending_d = '0;
    end else if (!drop) begin
      if (bus.req && !fire) begin
        pending_d = pending_q + 1'b1;
      end else if (!bus.req && fire) begin
        pending_d = pending_q - 1'b1;
      end
    end

    ovf_d = bus.clr ? 1'b0 : (ovf_q || drop);

    // The gap counter ignores clr so spacing from the last issued pulse always holds.
    if (fire) begin
      gap_cnt_d = GAP_LOAD;
    end else if (gap_zero) begin
      gap_cnt_d = '0;
    end else begin
      gap_cnt_d = gap_cnt_q - 1'b1;
    end

    pls_d = fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q <= '0;
      pending_q <= '0;
      pls_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
      pending_q <= pending_d;
      pls_q     <= pls_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.pls     = pls_q;
  assign bus.pending = pending_q;
  assign bus.ovf     = ovf_q;
  assign bus.busy    = (pending_q != '0) || (gap_cnt_q != '0) || pls_q;

endmodule

// File: tb/tb_pls_pacer.sv
// Bench for pls_pacer: directed vector table, multi-cycle corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_pls_pacer;

  localparam int pGAP   = 6;
  localparam int pCNT_W = 4;
  localparam int MAXP   = (1 << pCNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pls_pacer_if #(.pCNT_W(pCNT_W)) bus ();

  pls_pacer #(.pGAP(pGAP), .pCNT_W(pCNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit req;
    bit clr;
    bit pls;
    int pending;
    bit ovf;
    bit busy;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Reference model: state as of the current cycle, spacing tracked by last-fire timestamp.
  int m_pending;
  bit m_ovf;
  bit m_pls;
  int m_cyc;
  int m_last;

  int tcyc;
  int pls_count;
  int pls_at[$];
  int peak;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_pending = 0;
    m_ovf     = 1'b0;
    m_pls     = 1'b0;
    m_cyc     = 0;
    m_last    = -1000;
  endtask

  function automatic int modelBusy();
    return ((m_pending != 0) || m_pls || ((m_cyc - m_last) <= pGAP - 1)) ? 1 : 0;
  endfunction

  task automatic obsReset();
    tcyc      = 0;
    pls_count = 0;
    pls_at.delete();
    peak      = 0;
  endtask

  // One clock cycle: compare current outputs with the model, drive inputs, advance the model.
  task automatic applyStimulus(input bit r, input bit c);
    bit fire;
    int total;
    @(negedge clk);
    checkOutput("pls",     int'(bus.pls),     int'(m_pls));
    checkOutput("pending", int'(bus.pending), m_pending);
    checkOutput("ovf",     int'(bus.ovf),     int'(m_ovf));
    checkOutput("busy",    int'(bus.busy),    modelBusy());
    if (bus.pls) begin
      pls_count++;
      pls_at.push_back(tcyc);
    end
    if (int'(bus.pending) > peak) peak = int'(bus.pending);
    bus.req = r;
    bus.clr = c;
    fire = !c && ((m_cyc - m_last) >= pGAP) && ((m_pending != 0) || r);
    if (c) begin
      m_pending = 0;
      m_ovf     = 1'b0;
    end else begin
      total = m_pending + int'(r) - int'(fire);
      if (total > MAXP) begin
        total = MAXP;
        m_ovf = 1'b1;
      end
      m_pending = total;
    end
    m_pls = fire;
    if (fire) m_last = m_cyc;
    m_cyc++;
    tcyc++;
  endtask

  task automatic checkPulseTimes(input string name, input int exp_q[$]);
    checkOutput({name, "_count"}, pls_count, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < pls_at.size()) checkOutput({name, "_time"}, pls_at[i], exp_q[i]);
      else checkOutput({name, "_time"}, -1, exp_q[i]);
    end
  endtask

  initial begin
    vec_t tbl[14];
    int   dens;

    // Single request, then a request landing exactly as the gap expires.
    tbl[0]  = '{1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0};

    rst_n   = 1'b0;
    bus.req = 1'b0;
    bus.clr = 1'b0;
    modelReset();
    obsReset();
    #12;
    checkOutput("reset_pls",     int'(bus.pls),     0);
    checkOutput("reset_pending", int'(bus.pending), 0);
    checkOutput("reset_ovf",     int'(bus.ovf),     0);
    checkOutput("reset_busy",    int'(bus.busy),    0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

    $display("[TB] vector table: single req and req at gap expiry");
    obsReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].req, tbl[i].clr);
      checkOutput("tbl_pls",     int'(bus.pls),     int'(tbl[i].pls));
      checkOutput("tbl_pending", int'(bus.pending), tbl[i].pending);
      checkOutput("tbl_ovf",     int'(bus.ovf),     int'(tbl[i].ovf));
      checkOutput("tbl_busy",    int'(bus.busy),    int'(tbl[i].busy));
    end
    checkPulseTimes("tbl", '{1, 7});

    $display("[TB] burst of five requests");
    obsReset();
    for (int i = 0; i < 5; i++)  applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0);
    checkPulseTimes("burst5", '{1, 7, 13, 19, 25});
    checkOutput("burst5_peak", peak, 4);
    checkOutput("burst5_ovf", int'(bus.ovf), 0);

    $display("[TB] saturation with twenty requests");
    obsReset();
    for (int i = 0; i < 20; i++)  applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 110; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("sat_count", pls_count, 19);
    checkOutput("sat_peak", peak, MAXP);
    checkOutput("sat_ovf", int'(bus.ovf), 1);
    checkOutput("sat_last", (pls_at.size() > 0) ? pls_at[pls_at.size()-1] : -1, 109);

    $display("[TB] clear of a backlog of seven");
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("clr_ovf_gone", int'(bus.ovf), 0);
    obsReset();
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("clr_backlog", int'(bus.pending), 7);
    applyStimulus(1'b1, 1'b0);
    checkOutput("clr_pending", int'(bus.pending), 0);
    checkOutput("clr_ovf", int'(bus.ovf), 0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0);
    checkPulseTimes("clr", '{1, 7, 13});

    $display("[TB] asynchronous reset mid-backlog");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #2;
    bus.req = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkOutput("arst_pls",     int'(bus.pls),     0);
    checkOutput("arst_pending", int'(bus.pending), 0);
    checkOutput("arst_ovf",     int'(bus.ovf),     0);
    checkOutput("arst_busy",    int'(bus.busy),    0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    obsReset();
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("arst_quiet", pls_count, 0);

    $display("[TB] randomized traffic");
    for (int blk = 0; blk < 6; blk++) begin
      dens = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 95);
      for (int i = 0; i < 100; i++) begin
        applyStimulus($urandom_range(0, 99) < dens, $urandom_range(0, 79) == 0);
      end
    end
    for (int i = 0; i < 120; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("rand_drained", int'(bus.pending), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
